// File: rtl/ste_pkg.sv
// Shared types and helpers for the binary-to-BCD display scaling stage.
package ste_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    CONV
  } ste_b2b_state_t;

  typedef logic [3:0] bcd_digit_t;

  // 10^n, used to derive the saturation limit for a digit count.
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Bits needed to hold any value from 0 to 10^digits-1.
  function automatic int unsigned val_width(input int unsigned digits);
    return $clog2(pow10(digits));
  endfunction

  localparam int unsigned DEF_DIGITS = 5;
  localparam int unsigned VAL_W      = val_width(DEF_DIGITS);

endpackage

// File: rtl/ste_dd_step.sv
// One double-dabble step: add 3 to every digit above 4, then shift left
// by one bit, pulling the next binary bit in at the units end.
module ste_dd_step
  import ste_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                msb,
  output logic [4*DIGITS-1:0] bcd_next
);

  logic [4*DIGITS-1:0] corrected;

  // Per-digit add-3 correction followed by the one-bit shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    corrected = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_digit_t d;
      d = bcd[4*i +: 4];
      if (d > 4'd4) corrected[4*i +: 4] = d + 4'd3;
    end
    bcd_next = {corrected[4*DIGITS-2:0], msb};
  end

endmodule

// File: rtl/ste_bin2bcd_scale.sv
// Scales the averaged ADC code to display units, saturates to DIGITS
// decimal digits and converts to packed BCD one shift per clock.
module ste_bin2bcd_scale
  import ste_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          DIGITS      = 5,
  parameter int unsigned SCALE_MUL   = 3300,
  parameter int          SCALE_SHIFT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   din_i,
  input  logic                din_update_i,
  input  logic                conv_clr_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                bcd_update_o,
  output logic                ovf_o,
  output logic                busy_o
);

  localparam int unsigned MAX_V    = pow10(DIGITS) - 1;
  localparam int          VAL_BITS = val_width(DIGITS);
  localparam int          PROD_W   = DATA_W + 16;
  localparam int          CNT_W    = $clog2(VAL_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_BITS - 1);

  ste_b2b_state_t state, next_state;

  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   pending_data;
  logic                pending;
  logic [VAL_BITS-1:0] value;
  logic                ovf_r;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] acc_next;
  logic [CNT_W-1:0]    cnt;

  logic [PROD_W-1:0]   product;
  logic [PROD_W-1:0]   scaled;
  logic                sat;
  logic [VAL_BITS-1:0] clamped;
  logic                final_cycle;

  assign product     = PROD_W'(operand) * PROD_W'(SCALE_MUL);
  assign scaled      = product >> SCALE_SHIFT;
  assign sat         = scaled > PROD_W'(MAX_V);
  assign clamped     = sat ? VAL_BITS'(MAX_V) : scaled[VAL_BITS-1:0];
  assign final_cycle = (state == CONV) && (cnt == CNT_LAST);

  ste_dd_step #(.DIGITS(DIGITS)) u_dd_step (
    .bcd      (acc),
    .msb      (value[VAL_BITS-1]),
    .bcd_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a clear wins over everything, completions chain
  // straight into SCALE when a new or pending sample is available.
  always_comb begin
    next_state = state;
    if (conv_clr_i) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (din_update_i) next_state = SCALE;
        SCALE:   next_state = CONV;
        CONV:    if (final_cycle) next_state = (din_update_i || pending) ? SCALE : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output decode.
  assign busy_o = (state != IDLE);

  // Datapath: operand capture, pending buffer, scaling, shift-add, results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand      <= '0;
      pending_data <= '0;
      pending      <= 1'b0;
      value        <= '0;
      ovf_r        <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      bcd_o        <= '0;
      ovf_o        <= 1'b0;
      bcd_update_o <= 1'b0;
    end else begin
      bcd_update_o <= 1'b0;
      if (conv_clr_i) begin
        pending <= 1'b0;
        bcd_o   <= '0;
        ovf_o   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (din_update_i) operand <= din_i;
          end
          SCALE: begin
            value <= clamped;
            ovf_r <= sat;
            acc   <= '0;
            cnt   <= '0;
            if (din_update_i) begin
              pending_data <= din_i;
              pending      <= 1'b1;
            end
          end
          CONV: begin
            acc   <= acc_next;
            value <= {value[VAL_BITS-2:0], 1'b0};
            cnt   <= cnt + CNT_W'(1);
            if (final_cycle) begin
              bcd_o        <= acc_next;
              ovf_o        <= ovf_r;
              bcd_update_o <= 1'b1;
              if (din_update_i) begin
                operand <= din_i;
                pending <= 1'b0;
              end else if (pending) begin
                operand <= pending_data;
                pending <= 1'b0;
              end
            end else if (din_update_i) begin
              pending_data <= din_i;
              pending      <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ste_bin2bcd_scale.sv
// Bench for ste_bin2bcd_scale: two instances (default scaling and raw
// x65535 scaling) share one stimulus stream and are compared each cycle
// against a transaction-level model of the conversion pipeline.
module tb_ste_bin2bcd_scale;

  localparam int LAT = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        upd = 1'b0;
  logic        clr = 1'b0;

  logic [19:0] bcd_a, bcd_b;
  logic        bupd_a, bupd_b, ovf_a, ovf_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  bit          m_busy;
  int          m_remain;
  logic [15:0] m_cur;
  bit          m_pend;
  logic [15:0] m_pend_code;
  logic [19:0] e_bcd_a, e_bcd_b;
  logic        e_ovf_a, e_ovf_b, e_upd;

  always #5 clk = ~clk;

  ste_bin2bcd_scale u_dut_a (
    .clk(clk), .rst_n(rst_n), .din_i(din), .din_update_i(upd), .conv_clr_i(clr),
    .bcd_o(bcd_a), .bcd_update_o(bupd_a), .ovf_o(ovf_a), .busy_o(busy_a)
  );

  ste_bin2bcd_scale #(.SCALE_MUL(65535), .SCALE_SHIFT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .din_i(din), .din_update_i(upd), .conv_clr_i(clr),
    .bcd_o(bcd_b), .bcd_update_o(bupd_b), .ovf_o(ovf_b), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input longint unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Display value and overflow for a code under a given scaling.
  task automatic ref_result(input logic [15:0] code, input longint unsigned mul,
                            input int shift, output logic [19:0] bcd, output logic ovf);
    longint unsigned s;
    s = (longint'(code) * mul) >> shift;
    ovf = (s > 99999);
    bcd = to_bcd(ovf ? 99999 : s);
  endtask

  task automatic model_reset();
    m_busy = 0; m_remain = 0; m_cur = '0; m_pend = 0; m_pend_code = '0;
    e_bcd_a = '0; e_bcd_b = '0; e_ovf_a = 0; e_ovf_b = 0; e_upd = 0;
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_edge(input logic u, input logic [15:0] d, input logic c);
    e_upd = 0;
    if (c) begin
      m_busy = 0; m_pend = 0;
      e_bcd_a = '0; e_bcd_b = '0; e_ovf_a = 0; e_ovf_b = 0;
    end else if (!m_busy) begin
      if (u) begin m_busy = 1; m_remain = LAT; m_cur = d; end
    end else begin
      m_remain--;
      if (m_remain == 0) begin
        ref_result(m_cur, 3300, 16, e_bcd_a, e_ovf_a);
        ref_result(m_cur, 65535, 0, e_bcd_b, e_ovf_b);
        e_upd = 1;
        if (u) begin
          m_cur = d; m_remain = LAT; m_pend = 0;
        end else if (m_pend) begin
          m_cur = m_pend_code; m_remain = LAT; m_pend = 0;
        end else begin
          m_busy = 0;
        end
      end else if (u) begin
        m_pend = 1; m_pend_code = d;
      end
    end
  endtask

  task automatic check_all();
    check("upd_a",  32'(bupd_a), 32'(e_upd));
    check("upd_b",  32'(bupd_b), 32'(e_upd));
    check("busy_a", 32'(busy_a), 32'(m_busy));
    check("busy_b", 32'(busy_b), 32'(m_busy));
    check("bcd_a",  32'(bcd_a),  32'(e_bcd_a));
    check("bcd_b",  32'(bcd_b),  32'(e_bcd_b));
    check("ovf_a",  32'(ovf_a),  32'(e_ovf_a));
    check("ovf_b",  32'(ovf_b),  32'(e_ovf_b));
  endtask

  // Called at a negedge: drive, take the edge, check at the next negedge.
  task automatic cycle(input logic u, input logic [15:0] d, input logic c);
    upd = u; din = d; clr = c;
    @(posedge clk);
    model_edge(u, d, c);
    @(negedge clk);
    upd = 1'b0; clr = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, din, 1'b0);
  endtask

  int pulses;

  initial begin
    model_reset();
    #17;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Mid-scale code, then full-scale and zero.
    cycle(1'b1, 16'h8000, 1'b0); idle(22);
    cycle(1'b1, 16'hFFFF, 1'b0); idle(22);
    cycle(1'b1, 16'h0000, 1'b0); idle(22);
    // Saturating and non-saturating codes for the raw scaling instance.
    cycle(1'b1, 16'h0005, 1'b0); idle(22);
    cycle(1'b1, 16'h0001, 1'b0); idle(22);

    // Back-to-back updates spaced 3 cycles: newest pending sample wins.
    pulses = 0;
    cycle(1'b1, 16'h1000, 1'b0); idle(2);
    cycle(1'b1, 16'h2000, 1'b0); idle(2);
    cycle(1'b1, 16'h3000, 1'b0);
    for (int i = 0; i < 45; i++) begin
      cycle(1'b0, din, 1'b0);
      if (bupd_a) pulses++;
    end
    check("pulse_count", 32'(pulses), 32'd2);

    // Clear in the same cycle as an update, with a pending sample held.
    cycle(1'b1, 16'h4000, 1'b0); idle(3);
    cycle(1'b1, 16'h5000, 1'b0); idle(4);
    cycle(1'b1, 16'h6000, 1'b1);
    check("clr_busy", 32'(busy_a), 32'd0);
    idle(30);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 7) == 0, 16'($urandom_range(0, 65535)),
            $urandom_range(0, 63) == 0);
    idle(40);

    // Asynchronous reset mid-conversion with non-zero outputs.
    cycle(1'b1, 16'hFFFF, 1'b0); idle(25);
    cycle(1'b1, 16'h9000, 1'b0); idle(8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(25);
    cycle(1'b1, 16'h8000, 1'b0); idle(22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
